// File: rtl/bt_frame_tx_pkg.sv
// Shared constants, state encoding and checksum helper
// for the servo-channel frame transmitter.
package bt_frame_tx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
    localparam int         TIMEOUT_CYC_DEF = 4096;
    localparam int         FRAME_LEN       = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    // 8-bit wrapping sum of the count byte and all eight channels
    function automatic logic [7:0] frame_csum(
        input logic [7:0]  cnt,
        input logic [63:0] ch
    );
        logic [7:0] s;
        s = cnt;
        for (int i = 0; i < 8; i++) begin
            s = s + ch[i*8 +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/bt_frame_tx.sv
// Frame sequencer feeding an external byte UART:
// SYNC, count, eight channel bytes, checksum.
module bt_frame_tx
    import bt_frame_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic [63:0] ch_bytes,
    input  logic        tx_done,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [7:0]  frame_cnt,
    output logic [7:0]  overrun_cnt,
    output logic        timeout_err
);

    localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    state_t          state;
    state_t          state_nx;
    logic [63:0]     ch_q;
    logic [7:0]      cnt_q;
    logic [7:0]      csum_q;
    logic [3:0]      idx_q;
    logic [3:0]      idx_nx;
    logic [TW-1:0]   to_q;
    logic            adv_q;
    logic            accept;
    logic            drop;
    logic            load_data;
    logic            advance;
    logic            frame_end;
    logic            to_hit;
    logic [2:0]      ch_sel;
    logic [7:0]      byte_sel;

    assign tx_en = (state == ST_SEND);
    assign busy  = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and control strobes; a non-final TX_DONE spends
    // one extra WAIT cycle (adv_q) before the next SEND
    always_comb begin
        state_nx  = state;
        idx_nx    = idx_q;
        accept    = 1'b0;
        load_data = 1'b0;
        advance   = 1'b0;
        frame_end = 1'b0;
        to_hit    = 1'b0;
        drop      = start && enable && (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (start && enable) begin
                    accept   = 1'b1;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_nx    = 4'd0;
                load_data = 1'b1;
                state_nx  = ST_SEND;
            end
            ST_SEND: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (adv_q) begin
                    state_nx = ST_SEND;
                end else if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        frame_end = 1'b1;
                        state_nx  = ST_IDLE;
                    end else begin
                        advance   = 1'b1;
                        idx_nx    = idx_q + 4'd1;
                        load_data = 1'b1;
                    end
                end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                    to_hit   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Byte select over the snapshot, indexed by the upcoming byte
    always_comb begin
        ch_sel   = 3'(idx_nx - 4'd2);
        byte_sel = 8'h00;
        if (idx_nx == 4'd0) begin
            byte_sel = SYNC_BYTE;
        end else if (idx_nx == 4'd1) begin
            byte_sel = cnt_q;
        end else if (idx_nx == LAST_IDX) begin
            byte_sel = csum_q;
        end else if (idx_nx <= 4'd9) begin
            byte_sel = ch_q[{ch_sel, 3'b000} +: 8];
        end
    end

    // Snapshot, byte sequencing, timeout and status counters
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q        <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            to_q        <= '0;
            adv_q       <= 1'b0;
            tx_data     <= '0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                ch_q  <= ch_bytes;
                cnt_q <= frame_cnt;
            end
            if (state == ST_LOAD) begin
                csum_q <= frame_csum(cnt_q, ch_q);
            end
            idx_q <= idx_nx;
            adv_q <= advance;
            if (state == ST_WAIT && !adv_q) begin
                to_q <= to_q + 1'b1;
            end else begin
                to_q <= '0;
            end
            if (load_data) begin
                tx_data <= byte_sel;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (drop && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (to_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bt_frame_tx.sv
// Directed bench for bt_frame_tx with a UART model and a
// byte scoreboard; a second instance covers the timeout path.
module tb_bt_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic [63:0] ch_bytes = '0;
    logic        tx_done = 1'b0;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic [7:0]  overrun_cnt;
    logic        timeout_err;

    logic        t_start = 1'b0;
    logic        t_done = 1'b0;
    logic        t_en;
    logic [7:0]  t_data;
    logic        t_busy;
    logic [7:0]  t_fcnt;
    logic [7:0]  t_ovr;
    logic        t_terr;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          exp_en_cyc = -1;
    int          last_done = -1;
    int          cd = 0;
    int          dly = 20;
    int          n_en = 0;
    int          drops = 0;
    logic [7:0]  mcnt = 8'h00;
    logic [7:0]  sb[$];

    bt_frame_tx dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start       (start),
        .ch_bytes    (ch_bytes),
        .tx_done     (tx_done),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    bt_frame_tx #(.TIMEOUT_CYC(16)) dut_to (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start       (t_start),
        .ch_bytes    (ch_bytes),
        .tx_done     (t_done),
        .tx_en       (t_en),
        .tx_data     (t_data),
        .busy        (t_busy),
        .frame_cnt   (t_fcnt),
        .overrun_cnt (t_ovr),
        .timeout_err (t_terr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [7:0] c,
                                              input logic [63:0] ch,
                                              input int i);
        logic [7:0] s;
        if (i == 0) return 8'hA5;
        if (i == 1) return c;
        if (i >= 2 && i <= 9) return ch[(i-2)*8 +: 8];
        s = c;
        for (int j = 0; j < 8; j++) s = s + ch[j*8 +: 8];
        return s;
    endfunction

    task automatic push_frame(input logic [7:0] c, input logic [63:0] ch);
        for (int i = 0; i < 11; i++) sb.push_back(frame_byte(c, ch, i));
    endtask

    // UART model: checks each byte and its issue cycle, answers
    // with TX_DONE dly cycles after TX_EN
    always @(negedge clk) begin
        logic [15:0] e;
        tx_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                tx_done = 1'b1;
                if (sb.size() == 0) begin
                    last_done  = cyc;
                    exp_en_cyc = -1;
                end else begin
                    exp_en_cyc = cyc + 2;
                end
            end
        end
        if (tx_en) begin
            n_en++;
            chk("tx_en_cycle", 64'(cyc), 64'(exp_en_cyc));
            e = (sb.size() > 0) ? {8'h00, sb.pop_front()} : 16'hDEAD;
            chk("tx_byte", {56'h0, tx_data}, {48'h0, e});
            cd = dly;
        end
    end

    // mode 0: plain frame, 1: START every 5 cycles, 2: ENABLE drops
    task automatic send_frame(input logic [63:0] ch, input int mode);
        int k;
        push_frame(mcnt, ch);
        ch_bytes   = ch;
        start      = 1'b1;
        exp_en_cyc = cyc + 2;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        k = 0;
        while (busy && k < 20000) begin
            start = 1'b0;
            if (mode == 1 && k % 5 == 4) begin
                start    = 1'b1;
                ch_bytes = {$urandom, $urandom};
                drops++;
            end
            if (mode == 2 && k == 10) enable = 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("frame_end_bound", busy, 0);
        chk("idle_after_done", 64'(cyc), 64'(last_done + 1));
        chk("sb_drained", 64'(sb.size()), 0);
        mcnt++;
        chk("frame_cnt", frame_cnt, mcnt);
    endtask

    task automatic t_wait_en(input string tag);
        int k;
        k = 0;
        while (!t_en && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, t_en, 1);
    endtask

    task automatic t_ack();
        repeat (3) @(negedge clk);
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
    endtask

    initial begin
        int          base;
        int          k;
        int          seen;
        int          e;
        logic [63:0] tch;

        repeat (3) @(negedge clk);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_overrun", overrun_cnt, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        dly = 20;
        send_frame(64'h0706050403020100, 0);

        dly = 2;
        for (int f = 0; f < 255; f++) send_frame({8{8'hFF}}, 0);
        chk("frame_cnt_wrap", frame_cnt, 8'h00);

        dly   = 45;
        drops = 0;
        send_frame(64'h8877665544332211, 1);
        chk("overrun_first", overrun_cnt, 64'(drops));
        send_frame(64'h0123456789ABCDEF, 1);
        send_frame(64'hF0E1D2C3B4A59687, 1);
        chk("overrun_drops_gt255", 64'(drops > 255), 1);
        chk("overrun_sat", overrun_cnt, 8'hFF);

        dly = 2;
        send_frame(64'h1020304050607080, 2);
        enable = 1'b1;

        dly = 20;
        base = n_en;
        push_frame(mcnt, 64'hCAFEBABE12345678);
        ch_bytes   = 64'hCAFEBABE12345678;
        start      = 1'b1;
        exp_en_cyc = cyc + 2;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (n_en < base + 5 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_byte5", 64'(n_en), 64'(base + 5));
        repeat (8) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        sb.delete();
        exp_en_cyc = -1;
        @(negedge clk);
        chk("mid_rst_tx_en", tx_en, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_overrun", overrun_cnt, 0);
        chk("mid_rst_terr", timeout_err, 0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        mcnt  = 8'h00;
        base  = n_en;
        @(negedge clk);
        chk("start_in_rst_busy", busy, 0);
        enable = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_tx_en_after_rst", 64'(n_en), 64'(base));
        chk("dis_start_overrun", overrun_cnt, 0);
        chk("dis_start_busy", busy, 0);
        enable = 1'b1;
        dly    = 2;
        send_frame(64'h0F1E2D3C4B5A6978, 0);

        tch      = 64'h1122334455667788;
        ch_bytes = tch;
        t_start  = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            t_wait_en("to_en_seen");
            chk("to_byte", t_data, frame_byte(8'h00, tch, b));
            if (b < 2) t_ack();
        end
        e    = cyc;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (t_en) seen++;
        end
        chk("to_busy_before", t_busy, 1);
        chk("to_cycle_count", 64'(cyc), 64'(e + 16));
        @(negedge clk);
        chk("to_busy_after", t_busy, 0);
        chk("to_err_set", t_terr, 1);
        chk("to_frame_cnt", t_fcnt, 0);
        chk("to_no_en", 64'(seen), 0);
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        for (int b = 0; b < 11; b++) begin
            t_wait_en("to2_en_seen");
            chk("to2_byte", t_data, frame_byte(8'h00, tch, b));
            t_ack();
        end
        @(negedge clk);
        chk("to2_busy", t_busy, 0);
        chk("to2_frame_cnt", t_fcnt, 8'h01);
        chk("to2_err_sticky", t_terr, 1);
        chk("to2_overrun", t_ovr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bt_frame_tx.md
BT_FRAME_TX -- requirements
Module: bt_frame_tx

Interface
REQ-001 SYNC_BYTE, 8'hA5, first byte of every frame.
REQ-002 TIMEOUT_CYC, 4096, maximum CLK cycles to wait for TX_DONE per byte.
REQ-003 CLK  in  1  system clock (16 MHz); all logic on posedge CLK.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 ENABLE  in  1  transmit permission; START ignored while low.
REQ-006 START  in  1  one-cycle pulse: snapshot CH_BYTES and send one frame.
REQ-007 CH_BYTES  in  64  eight channel bytes; [7:0] = channel 1 (sent first), [63:56] = channel 8.
REQ-008 TX_DONE  in  1  one-cycle pulse from the UART transmitter: current byte finished.
REQ-009 TX_EN  out  1  one-cycle pulse: UART shall start sending TX_DATA.
REQ-010 TX_DATA  out  8  byte to send; held stable from the TX_EN cycle until TX_DONE.
REQ-011 BUSY  out  1  high from the cycle after an accepted START until the frame ends.
REQ-012 FRAME_CNT  out  8  count of completed frames, wraps 255->0.
REQ-013 OVERRUN_CNT  out  8  count of dropped STARTs, saturates at 255.
REQ-014 TIMEOUT_ERR  out  1  sticky; set on a TX_DONE timeout; cleared only by RST.

Function
REQ-015 Frame layout, 11 bytes: SYNC_BYTE, FRAME_CNT, CH1..CH8, CHECKSUM.
- FRAME_CNT is sent as its value before the increment.
REQ-016 CHECKSUM = (FRAME_CNT + CH1 + ... + CH8) mod 256, 8-bit wrap; SYNC_BYTE excluded.
REQ-017 States:
- IDLE: START & ENABLE -> LOAD.
- LOAD -> SEND.
- SEND -> WAIT.
- WAIT: on TX_DONE, go to SEND if bytes remain, else IDLE.
- WAIT: on timeout -> IDLE.
REQ-018 An accepted START (IDLE, ENABLE=1) registers CH_BYTES and FRAME_CNT; later CH_BYTES changes do not affect the frame.
REQ-019 Latency: START accepted in cycle n -> TX_EN=1 with TX_DATA=SYNC_BYTE in cycle n+2.
REQ-020 TX_EN is high for exactly one cycle per byte, in SEND only.
REQ-021 TX_DONE in cycle m while in WAIT, more bytes remaining -> TX_EN for the next byte in cycle m+2.
REQ-022 TX_DONE received in IDLE, LOAD or SEND is ignored.
REQ-023 START & ENABLE when not IDLE: frame not queued; OVERRUN_CNT += 1, saturating.
REQ-024 START with ENABLE=0: ignored; OVERRUN_CNT unchanged.
REQ-025 ENABLE falling mid-frame: the current frame completes normally.
REQ-026 At the TX_DONE of the CHECKSUM byte: FRAME_CNT += 1 and BUSY=0 in the next cycle.
REQ-027 A START in the cycle the frame returns to IDLE is accepted.
REQ-028 Timeout: WAIT lasting TIMEOUT_CYC cycles without TX_DONE ->
- abort to IDLE; set TIMEOUT_ERR;
- FRAME_CNT unchanged; partial frame not retried.
REQ-029 Timeout counter restarts on every entry to WAIT.

Reset
REQ-030 While RST=1, in the same clock edge:
- state=IDLE; TX_EN=0, TX_DATA=0, BUSY=0;
- FRAME_CNT=0, OVERRUN_CNT=0, TIMEOUT_ERR=0;
- byte index and timeout counter cleared.
REQ-031 RST mid-frame aborts at once; no further TX_EN until a new START is accepted after RST falls.
REQ-032 START during RST is ignored.

Structure
REQ-033 Shared package holds:
- SYNC_BYTE default, FRAME_LEN=11;
- state encoding IDLE/LOAD/SEND/WAIT.
REQ-034 Single module with no sub-module; byte select is a mux on a 4-bit index over the snapshot register.
REQ-035 UART_rs232_tx stays external; TX_EN/TX_DATA/TX_DONE connect to it directly.

Verification
REQ-036 FRAME_CNT=0, CH_BYTES bytes 00..07 (CH1=00), START; UART model returns TX_DONE 20 cycles after each TX_EN -> bytes sent A5 00 00 01 02 03 04 05 06 07 1C; FRAME_CNT=1.
REQ-037 256 back-to-back frames with all CH bytes FF -> last frame's count byte is FF with checksum F7; FRAME_CNT wraps to 00.
REQ-038 START every 5 cycles during one frame (about 100 dropped) -> OVERRUN_CNT counts each drop, then saturates at FF after 255; frame content unchanged.
REQ-039 TIMEOUT_CYC=16, TX_DONE withheld after the 3rd byte -> abort 16 cycles after entering WAIT; TIMEOUT_ERR=1, BUSY=0, FRAME_CNT unchanged; next START sends a full frame.
REQ-040 RST asserted during byte 5 -> outputs at reset values next cycle, no further TX_EN; START with ENABLE=0 -> no TX_EN, OVERRUN_CNT=0.
